id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 121 ++++++++++++
 tb/tb_id_ex_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand selection, WB bypass and load-use stall detection.
// Optional feature: define ID_BYPASS_EN to forward WB write data into the captured operands.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [15:0] id_imm,
    input  logic [9:0]  id_ctrl,
    input  logic [31:0] rf_data1,
    input  logic [31:0] rf_data2,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    output logic        ex_valid,
    output logic [31:0] ex_rs_val,
    output logic [31:0] ex_rt_val,
    output logic [31:0] ex_imm32,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dest,
    output logic [9:0]  ex_ctrl,
    output logic        stall_out
);

    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_ALU_SRC   = 4;
    localparam int CTRL_REG_DST   = 5;

`ifdef ID_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    logic        ex_valid_q,  ex_valid_d;
    logic [31:0] ex_rs_val_q, ex_rs_val_d;
    logic [31:0] ex_rt_val_q, ex_rt_val_d;
    logic [31:0] ex_imm32_q,  ex_imm32_d;
    logic [4:0]  ex_rs_q,     ex_rs_d;
    logic [4:0]  ex_rt_q,     ex_rt_d;
    logic [4:0]  ex_dest_q,   ex_dest_d;
    logic [9:0]  ex_ctrl_q,   ex_ctrl_d;

    logic wb_hit_rs;
    logic wb_hit_rt;
    logic load_use;
    logic hazard;

    // Without bypass, a same-cycle WB write to a source must be waited out for one cycle.
    always_comb begin
        wb_hit_rs = wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == id_rs);
        wb_hit_rt = wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == id_rt);
        load_use  = ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] && (ex_dest_q != 5'd0) && id_valid &&
                    ((ex_dest_q == id_rs) ||
                     ((ex_dest_q == id_rt) && (!id_ctrl[CTRL_ALU_SRC] || id_ctrl[CTRL_MEM_WRITE])));
        hazard    = load_use || (!BYPASS_EN && id_valid && (wb_hit_rs || wb_hit_rt));
        stall_out = hazard && !flush && !rst;
    end

    always_comb begin
        ex_rs_d    = id_rs;
        ex_rt_d    = id_rt;
        ex_imm32_d = {{16{id_imm[15]}}, id_imm};
        ex_dest_d  = id_ctrl[CTRL_REG_DST] ? id_rd : id_rt;

        if (id_rs == 5'd0)
            ex_rs_val_d = 32'd0;
        else if (BYPASS_EN && wb_hit_rs)
            ex_rs_val_d = wb_write_data;
        else
            ex_rs_val_d = rf_data1;

        if (id_rt == 5'd0)
            ex_rt_val_d = 32'd0;
        else if (BYPASS_EN && wb_hit_rt)
            ex_rt_val_d = wb_write_data;
        else
            ex_rt_val_d = rf_data2;

        // Flush, stall and an empty ID slot all collapse to a bubble with cleared control.
        ex_valid_d = id_valid && !flush && !hazard;
        ex_ctrl_d  = ex_valid_d ? id_ctrl : 10'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_rs_val_q <= 32'd0;
            ex_rt_val_q <= 32'd0;
            ex_imm32_q  <= 32'd0;
            ex_rs_q     <= 5'd0;
            ex_rt_q     <= 5'd0;
            ex_dest_q   <= 5'd0;
            ex_ctrl_q   <= 10'd0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rs_val_q <= ex_rs_val_d;
            ex_rt_val_q <= ex_rt_val_d;
            ex_imm32_q  <= ex_imm32_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_dest_q   <= ex_dest_d;
            ex_ctrl_q   <= ex_ctrl_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_rs_val = ex_rs_val_q;
    assign ex_rt_val = ex_rt_val_q;
    assign ex_imm32  = ex_imm32_q;
    assign ex_rs     = ex_rs_q;
    assign ex_rt     = ex_rt_q;
    assign ex_dest   = ex_dest_q;
    assign ex_ctrl   = ex_ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions push the expected EX state,
// a monitor pops and compares after every rising edge.
module tb_id_ex_stage;

    localparam logic [9:0] CT_RTYPE = 10'h0A1;
    localparam logic [9:0] CT_LW    = 10'h01B;
    localparam logic [9:0] CT_SW    = 10'h014;
    localparam logic [9:0] CT_ADDI  = 10'h011;

    typedef struct packed {
        logic        valid;
        logic [9:0]  ctrl;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic [15:0] id_imm = '0;
    logic [9:0]  id_ctrl = '0;
    logic [31:0] rf_data1 = '0, rf_data2 = '0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_write_reg = '0;
    logic [31:0] wb_write_data = '0;
    logic        ex_valid;
    logic [31:0] ex_rs_val, ex_rt_val, ex_imm32;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic [9:0]  ex_ctrl;
    logic        stall_out;

    int   compared = 0;
    int   mismatched = 0;
    exp_t sb_q[$];
    int   step_q[$];

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .ex_valid(ex_valid), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm32(ex_imm32),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_ctrl(ex_ctrl), .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk_exp(input logic v, input logic [9:0] c, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] imm,
                                    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] d);
        exp_t e;
        e = '{valid: v, ctrl: c, rs_val: a, rt_val: b, imm: imm, rs: rs, rt: rt, dest: d};
        return e;
    endfunction

    task automatic check_output(input string name, input int step, input logic [31:0] act,
                                input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s step %0d: got %h required %h", name, step, act, req);
        end
    endtask

    task automatic apply_stimulus(input int step, input logic fl, input logic v,
                                  input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [15:0] imm, input logic [9:0] ctrl,
                                  input logic [31:0] rf1, input logic [31:0] rf2,
                                  input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd,
                                  input logic exp_stall, input exp_t e);
        @(negedge clk);
        flush = fl; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_imm = imm; id_ctrl = ctrl; rf_data1 = rf1; rf_data2 = rf2;
        wb_reg_write = wbw; wb_write_reg = wbr; wb_write_data = wbd;
        #1;
        check_output("stall_out", step, {31'd0, stall_out}, {31'd0, exp_stall});
        sb_q.push_back(e);
        step_q.push_back(step);
    endtask

    task automatic check_all_zero(input int step);
        check_output("stall_out", step, {31'd0, stall_out}, 32'd0);
        check_output("ex_valid", step, {31'd0, ex_valid}, 32'd0);
        check_output("ex_ctrl", step, {22'd0, ex_ctrl}, 32'd0);
        check_output("ex_rs_val", step, ex_rs_val, 32'd0);
        check_output("ex_rt_val", step, ex_rt_val, 32'd0);
        check_output("ex_imm32", step, ex_imm32, 32'd0);
        check_output("ex_rs", step, {27'd0, ex_rs}, 32'd0);
        check_output("ex_rt", step, {27'd0, ex_rt}, 32'd0);
        check_output("ex_dest", step, {27'd0, ex_dest}, 32'd0);
    endtask

    // Monitor: one expected EX state per issued instruction slot; bubbles compare valid/ctrl only.
    initial begin
        exp_t e, act;
        int   s;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                s = step_q.pop_front();
                act = '{valid: ex_valid, ctrl: ex_ctrl, rs_val: ex_rs_val, rt_val: ex_rt_val,
                        imm: ex_imm32, rs: ex_rs, rt: ex_rt, dest: ex_dest};
                if (!e.valid) begin
                    act.rs_val = '0; act.rt_val = '0; act.imm = '0;
                    act.rs = '0; act.rt = '0; act.dest = '0;
                end
                compared++;
                if (act !== e) begin
                    mismatched++;
                    $display("[TB] FAIL ex_state step %0d: got %h required %h", s, act, e);
                end
            end
        end
    end

    initial begin
        exp_t bub;
        bub = '0;

        #1 rst = 1'b1;
        #1 check_all_zero(0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        apply_stimulus(1, 0, 1, 5'd3, 5'd2, 5'd7, 16'h8000, CT_RTYPE, 32'h11, 32'h22, 0, 5'd0, 32'h0,
                       0, mk_exp(1, CT_RTYPE, 32'h11, 32'h22, 32'hFFFF8000, 5'd3, 5'd2, 5'd7));
        apply_stimulus(2, 0, 1, 5'd1, 5'd5, 5'd0, 16'h0004, CT_LW, 32'h100, 32'h999, 0, 5'd0, 32'h0,
                       0, mk_exp(1, CT_LW, 32'h100, 32'h999, 32'h4, 5'd1, 5'd5, 5'd5));
        apply_stimulus(3, 0, 1, 5'd5, 5'd2, 5'd6, 16'h0000, CT_RTYPE, 32'h55, 32'h22, 0, 5'd0, 32'h0,
                       1, bub);
        apply_stimulus(4, 0, 1, 5'd5, 5'd2, 5'd6, 16'h0000, CT_RTYPE, 32'h55, 32'h22, 0, 5'd0, 32'h0,
                       0, mk_exp(1, CT_RTYPE, 32'h55, 32'h22, 32'h0, 5'd5, 5'd2, 5'd6));
        apply_stimulus(5, 0, 1, 5'd2, 5'd8, 5'd0, 16'hFFFC, CT_LW, 32'h200, 32'h0, 0, 5'd0, 32'h0,
                       0, mk_exp(1, CT_LW, 32'h200, 32'h0, 32'hFFFFFFFC, 5'd2, 5'd8, 5'd8));
        apply_stimulus(6, 0, 1, 5'd3, 5'd8, 5'd0, 16'h0010, CT_ADDI, 32'h33, 32'h44, 0, 5'd0, 32'h0,
                       0, mk_exp(1, CT_ADDI, 32'h33, 32'h44, 32'h10, 5'd3, 5'd8, 5'd8));
        apply_stimulus(7, 0, 1, 5'd0, 5'd10, 5'd0, 16'h0008, CT_LW, 32'hBADBAD, 32'h7, 0, 5'd0, 32'h0,
                       0, mk_exp(1, CT_LW, 32'h0, 32'h7, 32'h8, 5'd0, 5'd10, 5'd10));
        apply_stimulus(8, 0, 1, 5'd4, 5'd10, 5'd0, 16'h0000, CT_SW, 32'h44, 32'h1010, 0, 5'd0, 32'h0,
                       1, bub);
        apply_stimulus(9, 0, 1, 5'd4, 5'd10, 5'd0, 16'h0000, CT_SW, 32'h44, 32'h1010, 0, 5'd0, 32'h0,
                       0, mk_exp(1, CT_SW, 32'h44, 32'h1010, 32'h0, 5'd4, 5'd10, 5'd10));
        apply_stimulus(10, 0, 1, 5'd1, 5'd5, 5'd0, 16'h0000, CT_LW, 32'h100, 32'h0, 0, 5'd0, 32'h0,
                       0, mk_exp(1, CT_LW, 32'h100, 32'h0, 32'h0, 5'd1, 5'd5, 5'd5));
        apply_stimulus(11, 1, 1, 5'd5, 5'd2, 5'd6, 16'h0000, CT_RTYPE, 32'h55, 32'h22, 0, 5'd0, 32'h0,
                       0, bub);
        apply_stimulus(12, 0, 1, 5'd1, 5'd5, 5'd0, 16'h0000, CT_LW, 32'h100, 32'h0, 0, 5'd0, 32'h0,
                       0, mk_exp(1, CT_LW, 32'h100, 32'h0, 32'h0, 5'd1, 5'd5, 5'd5));
        apply_stimulus(13, 0, 0, 5'd5, 5'd5, 5'd6, 16'h1234, CT_RTYPE, 32'h55, 32'h22, 0, 5'd0, 32'h0,
                       0, bub);
`ifdef ID_BYPASS_EN
        apply_stimulus(14, 0, 1, 5'd4, 5'd3, 5'd6, 16'h0000, CT_RTYPE, 32'h1111, 32'h3333,
                       1, 5'd4, 32'hDEADBEEF,
                       0, mk_exp(1, CT_RTYPE, 32'hDEADBEEF, 32'h3333, 32'h0, 5'd4, 5'd3, 5'd6));
`else
        apply_stimulus(14, 0, 1, 5'd4, 5'd3, 5'd6, 16'h0000, CT_RTYPE, 32'h1111, 32'h3333,
                       1, 5'd4, 32'hDEADBEEF, 1, bub);
`endif
        apply_stimulus(15, 0, 1, 5'd4, 5'd3, 5'd6, 16'h0000, CT_RTYPE, 32'hDEADBEEF, 32'h3333,
                       0, 5'd0, 32'h0,
                       0, mk_exp(1, CT_RTYPE, 32'hDEADBEEF, 32'h3333, 32'h0, 5'd4, 5'd3, 5'd6));
`ifdef ID_BYPASS_EN
        apply_stimulus(16, 0, 1, 5'd1, 5'd7, 5'd9, 16'h0000, CT_RTYPE, 32'h1, 32'h0, 1, 5'd7, 32'h77,
                       0, mk_exp(1, CT_RTYPE, 32'h1, 32'h77, 32'h0, 5'd1, 5'd7, 5'd9));
`else
        apply_stimulus(16, 0, 1, 5'd1, 5'd7, 5'd9, 16'h0000, CT_RTYPE, 32'h1, 32'h0, 1, 5'd7, 32'h77,
                       1, bub);
`endif
        apply_stimulus(17, 0, 1, 5'd1, 5'd7, 5'd9, 16'h0000, CT_RTYPE, 32'h1, 32'h77, 0, 5'd0, 32'h0,
                       0, mk_exp(1, CT_RTYPE, 32'h1, 32'h77, 32'h0, 5'd1, 5'd7, 5'd9));
        apply_stimulus(18, 0, 1, 5'd0, 5'd0, 5'd3, 16'h0000, CT_RTYPE, 32'hFFFFFFFF, 32'hFFFFFFFF,
                       1, 5'd0, 32'h5,
                       0, mk_exp(1, CT_RTYPE, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3));
        apply_stimulus(19, 0, 1, 5'd2, 5'd3, 5'd4, 16'h0000, CT_RTYPE, 32'h22, 32'h33, 1, 5'd5, 32'h55,
                       0, mk_exp(1, CT_RTYPE, 32'h22, 32'h33, 32'h0, 5'd2, 5'd3, 5'd4));
        apply_stimulus(20, 0, 1, 5'd1, 5'd5, 5'd0, 16'h7FFF, CT_LW, 32'h100, 32'h0, 0, 5'd0, 32'h0,
                       0, mk_exp(1, CT_LW, 32'h100, 32'h0, 32'h00007FFF, 5'd1, 5'd5, 5'd5));

        // Reset asserted mid-cycle while a load-use stall is being requested.
        @(negedge clk);
        flush = 0; id_valid = 1; id_rs = 5'd5; id_rt = 5'd2; id_rd = 5'd6;
        id_imm = 16'h0; id_ctrl = CT_RTYPE; rf_data1 = 32'h55; rf_data2 = 32'h22;
        wb_reg_write = 0; wb_write_reg = 5'd0; wb_write_data = 32'h0;
        #1 check_output("stall_out", 21, {31'd0, stall_out}, 32'd1);
        #1 rst = 1'b1;
        #1 check_all_zero(21);
        @(negedge clk);
        rst = 1'b0;

        apply_stimulus(22, 0, 1, 5'd5, 5'd2, 5'd6, 16'h0000, CT_RTYPE, 32'h55, 32'h22, 0, 5'd0, 32'h0,
                       0, mk_exp(1, CT_RTYPE, 32'h55, 32'h22, 32'h0, 5'd5, 5'd2, 5'd6));

        @(negedge clk);
        check_output("scoreboard_drained", 23, sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
